// File: rtl/aes_axil_pkg.sv
// Shared register map, bit positions and response codes for the AES AXI4-Lite register file.
package aes_axil_pkg;

  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h04;
  localparam logic [5:0] OFF_KEY0   = 6'h10;
  localparam logic [5:0] OFF_KEY3   = 6'h1C;
  localparam logic [5:0] OFF_DIN0   = 6'h20;
  localparam logic [5:0] OFF_DIN3   = 6'h2C;
  localparam logic [5:0] OFF_DOUT0  = 6'h30;
  localparam logic [5:0] OFF_DOUT3  = 6'h3C;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned STATUS_BUSY = 0;
  localparam int unsigned STATUS_DONE = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_STATUS,
    SEL_KEY,
    SEL_DIN,
    SEL_DOUT,
    SEL_NONE
  } reg_sel_e;

  // Byte-lane bits are ignored: any access inside a word hits that word.
  function automatic reg_sel_e decode_off(input logic [5:0] off);
    logic [5:0] w;
    w = off & 6'h3C;
    if (w == OFF_CTRL)                        return SEL_CTRL;
    else if (w == OFF_STATUS)                 return SEL_STATUS;
    else if (w >= OFF_KEY0 && w <= OFF_KEY3)  return SEL_KEY;
    else if (w >= OFF_DIN0 && w <= OFF_DIN3)  return SEL_DIN;
    else if (w >= OFF_DOUT0 && w <= OFF_DOUT3) return SEL_DOUT;
    else                                      return SEL_NONE;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_axil_regs_if.sv
// AXI4-Lite bus bundle between the HPS lightweight bridge and the AES register file.
interface aes_axil_regs_if #(parameter int ADDR_W = 6);
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;

  modport master (
    output s_awaddr, s_awvalid, input s_awready,
    output s_wdata, s_wstrb, s_wvalid, input s_wready,
    input  s_bresp, s_bvalid, output s_bready,
    output s_araddr, s_arvalid, input s_arready,
    input  s_rdata, s_rresp, s_rvalid, output s_rready
  );

  modport slave (
    input  s_awaddr, s_awvalid, output s_awready,
    input  s_wdata, s_wstrb, s_wvalid, output s_wready,
    output s_bresp, s_bvalid, input s_bready,
    input  s_araddr, s_arvalid, output s_arready,
    output s_rdata, s_rresp, s_rvalid, input s_rready
  );
endinterface

// File: rtl/aes_axil_wr_ctrl.sv
// AXI4-Lite write front end: independent AW/W holding, single-cycle commit and B channel.
module aes_axil_wr_ctrl
  import aes_axil_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              commit,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [31:0]       commit_data,
  output logic [3:0]        commit_strb,
  input  logic              commit_err
);

  logic              aw_held, w_held;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [3:0]        strb_q;
  logic              aw_hs, w_hs;

  assign awready = !aw_held && !bvalid;
  assign wready  = !w_held && !bvalid;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // Commit uses a handshake in flight directly, so a joint AW+W beat answers next cycle.
  assign commit      = (aw_held || aw_hs) && (w_held || w_hs);
  assign commit_addr = aw_held ? addr_q : awaddr;
  assign commit_data = w_held ? data_q : wdata;
  assign commit_strb = w_held ? strb_q : wstrb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      if (bvalid && bready) bvalid <= 1'b0;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= commit_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          addr_q  <= awaddr;
        end
        if (w_hs) begin
          w_held <= 1'b1;
          data_q <= wdata;
          strb_q <= wstrb;
        end
      end
    end
  end

endmodule

// File: rtl/aes_axil_regs.sv
// AES accelerator register file on AXI4-Lite; optional level interrupt via AES_AXIL_IRQ_EN.
module aes_axil_regs
  import aes_axil_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  aes_axil_regs_if.slave       s,
  output logic [127:0]         core_key,
  output logic [127:0]         core_din,
  output logic                 core_start,
  input  logic [127:0]         core_dout,
  input  logic                 core_done
`ifdef AES_AXIL_IRQ_EN
  ,
  output logic                 irq
`endif
);

  logic [DATA_W-1:0] key_q  [4];
  logic [DATA_W-1:0] din_q  [4];
  logic [DATA_W-1:0] dout_q [4];
  logic              busy, done;
`ifdef AES_AXIL_IRQ_EN
  logic              irq_en;
`endif

  logic              commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              wr_err, wr_ok, start_go, done_clr;
  reg_sel_e          wr_sel, rd_sel;
  logic [31:0]       rd_data;
  logic              rd_err;

  function automatic reg_sel_e sel_of(input logic [ADDR_W-1:0] a);
    if ((a >> 6) != '0) return SEL_NONE;
    return decode_off(a[5:0]);
  endfunction

  aes_axil_wr_ctrl #(.ADDR_W(ADDR_W)) u_wr (
    .clk         (clk),
    .reset       (reset),
    .awaddr      (s.s_awaddr),
    .awvalid     (s.s_awvalid),
    .awready     (s.s_awready),
    .wdata       (s.s_wdata),
    .wstrb       (s.s_wstrb),
    .wvalid      (s.s_wvalid),
    .wready      (s.s_wready),
    .bresp       (s.s_bresp),
    .bvalid      (s.s_bvalid),
    .bready      (s.s_bready),
    .commit      (commit),
    .commit_addr (wr_addr),
    .commit_data (wr_data),
    .commit_strb (wr_strb),
    .commit_err  (wr_err)
  );

  always_comb begin
    wr_sel = sel_of(wr_addr);
    wr_err = 1'b0;
    case (wr_sel)
      SEL_NONE, SEL_DOUT: wr_err = 1'b1;
      SEL_KEY, SEL_DIN:   wr_err = busy;
      default:            wr_err = 1'b0;
    endcase
    wr_ok    = commit && !wr_err;
    start_go = wr_ok && wr_sel == SEL_CTRL && wr_strb[0] && wr_data[CTRL_START] && !busy;
    done_clr = wr_ok && wr_sel == SEL_STATUS && wr_strb[0] && wr_data[STATUS_DONE];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        key_q[i]  <= '0;
        din_q[i]  <= '0;
        dout_q[i] <= '0;
      end
      busy       <= 1'b0;
      done       <= 1'b0;
      core_start <= 1'b0;
`ifdef AES_AXIL_IRQ_EN
      irq_en     <= 1'b0;
      irq        <= 1'b0;
`endif
    end else begin
      core_start <= start_go;
      if (start_go) busy <= 1'b1;
      // A completion landing with a DONE clear keeps DONE set.
      if (core_done && busy) begin
        for (int unsigned i = 0; i < 4; i++) dout_q[i] <= core_dout[32*i +: 32];
        busy <= 1'b0;
        done <= 1'b1;
      end else if (done_clr) begin
        done <= 1'b0;
      end
      if (wr_ok && wr_sel == SEL_KEY)
        key_q[wr_addr[3:2]] <= merge_bytes(key_q[wr_addr[3:2]], wr_data, wr_strb);
      if (wr_ok && wr_sel == SEL_DIN)
        din_q[wr_addr[3:2]] <= merge_bytes(din_q[wr_addr[3:2]], wr_data, wr_strb);
`ifdef AES_AXIL_IRQ_EN
      if (wr_ok && wr_sel == SEL_CTRL && wr_strb[0]) irq_en <= wr_data[CTRL_IRQ_EN];
      irq <= done && irq_en;
`endif
    end
  end

  assign core_key = {key_q[3], key_q[2], key_q[1], key_q[0]};
  assign core_din = {din_q[3], din_q[2], din_q[1], din_q[0]};

  always_comb begin
    rd_sel  = sel_of(s.s_araddr);
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_sel)
`ifdef AES_AXIL_IRQ_EN
      SEL_CTRL:   rd_data[CTRL_IRQ_EN] = irq_en;
`endif
      SEL_STATUS: begin
        rd_data[STATUS_BUSY] = busy;
        rd_data[STATUS_DONE] = done;
      end
      SEL_KEY:    rd_data = key_q[s.s_araddr[3:2]];
      SEL_DIN:    rd_data = din_q[s.s_araddr[3:2]];
      SEL_DOUT:   rd_data = dout_q[s.s_araddr[3:2]];
      SEL_NONE:   rd_err = 1'b1;
      default:    rd_data = '0;
    endcase
  end

  assign s.s_arready = !s.s_rvalid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s.s_rvalid <= 1'b0;
      s.s_rdata  <= '0;
      s.s_rresp  <= RESP_OKAY;
    end else if (s.s_arvalid && !s.s_rvalid) begin
      s.s_rvalid <= 1'b1;
      s.s_rdata  <= rd_data;
      s.s_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s.s_rvalid && s.s_rready) begin
      s.s_rvalid <= 1'b0;
    end
  end

endmodule

// File: doc/aes_axil_regs.md
# aes_axil_regs

AXI4-Lite responder on the HPS-to-FPGA lightweight bridge that exposes the AES accelerator as a memory-mapped register file. It accepts HPS writes of key and plaintext words, launches the AES core with a single-cycle start pulse, and captures the core's 128-bit result for HPS readback. The block sits between the bridge master port in the platform system and the AES datapath core.

## Interface
Parameters:
- ADDR_W, 6, byte-address width of the AXI4-Lite port (64-byte window).
- DATA_W, 32, AXI data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_W/1/1  write address channel.
- s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  32/4/1/1  write data channel.
- s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  write response channel.
- s_araddr/s_arvalid/s_arready  in/in/out  ADDR_W/1/1  read address channel.
- s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  32/2/1/1  read data channel.
- core_key  out  128  key to the AES core; KEY0 = bits [31:0].
- core_din  out  128  plaintext to the AES core; DIN0 = bits [31:0].
- core_start  out  1  one-cycle launch pulse.
- core_dout  in  128  AES result; valid in the core_done cycle.
- core_done  in  1  one-cycle completion pulse.
- irq  out  1  level interrupt; present only with AES_AXIL_IRQ_EN.

## Operation
- Register map (byte offsets):
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0); bit1 IRQ_EN.
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, write-1-to-clear).
  - 0x10–0x1C KEY0–3: RW.
  - 0x20–0x2C DIN0–3: RW.
  - 0x30–0x3C DOUT0–3: RO.
- Write path:
  - AW and W are accepted independently, in either order, into holding registers.
  - s_awready = no AW held and !s_bvalid. s_wready = no W held and !s_bvalid.
  - Once both are held, the write commits in one cycle, both holders clear, and s_bvalid rises.
  - s_bvalid stays high until s_bready.
- Write strobes: honored per byte for KEY, DIN and CTRL. A CTRL write affects bits 0/1 only if s_wstrb[0]=1.
- Write errors: writes to DOUT, to unmapped offsets, or to KEY/DIN while BUSY=1 get s_bresp=2'b10 (SLVERR) and change no state. All other writes get 2'b00.
- START:
  - START=1 with BUSY=0 sets BUSY and pulses core_start on the cycle after commit.
  - START=1 with BUSY=1 is ignored and returns OKAY.
- Completion: core_done latches core_dout into DOUT0–3, clears BUSY and sets DONE. core_done while BUSY=0 is ignored.
- DONE conflict: if core_done and a DONE W1C land in the same cycle, set wins.
- Read path:
  - s_arready = !s_rvalid.
  - After an AR handshake, s_rdata/s_rresp are registered and s_rvalid rises the next cycle, holding until s_rready.
  - Unmapped reads return rdata=0, rresp=SLVERR.
- Reset values: every output and register is 0. Reset mid-transaction drops any pending AW/W/B/R and any in-flight core operation, and later core_done pulses are ignored (BUSY=0).

## Timing
- Write: s_bvalid is asserted 1 cycle after the later of the AW and W handshakes, so 1 cycle minimum when both arrive together.
- Read: s_rvalid is asserted 1 cycle after the AR handshake.
- Start: core_start is high exactly 1 cycle, in the same cycle as s_bvalid for the START write. BUSY reads 1 from that cycle on.
- Core hold: core_key/core_din are stable from core_start until core_done, guaranteed by the BUSY write lock.
- Concurrency: reads and writes proceed concurrently with no ordering between the two channels.

## Configuration
- AES_AXIL_IRQ_EN defined: irq = DONE & IRQ_EN, registered, 1-cycle lag. Clearing DONE or IRQ_EN deasserts irq on the following cycle.
- AES_AXIL_IRQ_EN undefined: the irq port is absent, and CTRL bit1 is not stored (reads 0, writes ignored).

## Structure
- Package aes_axil_pkg holds:
  - register offset localparams;
  - STATUS/CTRL bit indices;
  - AXI resp encodings (RESP_OKAY, RESP_SLVERR).
- One natural sub-module: aes_axil_wr_ctrl, holding the AW/W holding registers, the commit decision and the B channel. Read path and register file stay in the top.

## Test plan
- Write KEY0–3 = 0x2b7e1516/0x28aed2a6/0xabf71588/0x09cf4f3c and DIN0–3, then read them back -> identical values, all OKAY, core_key[31:0]=0x2b7e1516.
- Present W two cycles before AW to DIN1 -> no commit until AW; bvalid 1 cycle after AW handshake; DIN1 updated.
- Write CTRL=1 -> core_start 1-cycle pulse, STATUS=0x1. Core returns core_done with dout 0x3925841d_02dc09fb_dc118597_196a0b32 -> STATUS=0x2, DOUT0=0x196a0b32.
- While BUSY, write DIN0=0xFFFFFFFF -> bresp=SLVERR, DIN0 unchanged. Write CTRL=1 -> OKAY, no core_start.
- Read 0x08 and write 0x34 -> SLVERR on both; read data 0.
- With macro: IRQ_EN=1, complete a run -> irq=1. W1C STATUS=0x2 in the same cycle as a new core_done -> DONE stays 1, irq stays 1.
